gray_updown_counter: RTL
========================

# gray_updown_counter

Parametrised Gray-code counter with a built-in clock-enable prescaler, up/down counting, parallel load, and selectable wrap or saturate mode. It replaces the fixed-width, up-only Gray counter driven by an external slow enable. It sits between clk_25mhz-domain control logic and slow indicators (LEDs) or cross-domain consumers that need single-bit-change counts. It provides registered Gray and binary views plus step, change and terminal-count strobes.

## Interface
- bits, 8: counter width, legal 2..32
- div, 1: prescaler ratio, legal 1..2^24; one count step per div enabled cycles
- saturate, 0: 0 = wrap at limits, 1 = hold at limits

- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enable  in  1  prescaler advance qualifier
- up  in  1  direction: 1 = increment, 0 = decrement; sampled on step edges only
- load  in  1  synchronous parallel load strobe
- load_value  in  bits  Gray-coded value to load
- gray_count  out  bits  registered Gray count
- bin_count  out  bits  registered binary count, always consistent with gray_count
- tick  out  1  one-cycle pulse: a step was taken on the preceding edge
- changed  out  1  one-cycle pulse: count value changed on the preceding edge
- terminal  out  1  one-cycle pulse: step attempted at limit (max going up, 0 going down)

## Operation
- Internal state: binary register B[bits-1:0], prescaler P of width clog2(div) (absent/zero when div=1).
- Priority per edge: reset > load > step > hold.
- Prescaler: when enable=1 and no load, P increments. At P==div-1 a step occurs and P returns to 0. enable=0 freezes P. With div=1, a step occurs on every enabled edge.
- Step, up=1: B<MAX gives B+1. B==MAX gives 0 (wrap) or MAX (saturate, terminal=1, changed=0).
- Step, up=0: B>0 gives B-1. B==0 gives MAX (wrap) or 0 (saturate, terminal=1, changed=0).
- terminal pulses on every step taken at a limit, in both modes.
- Load: B <= gray2bin(load_value), P <= 0, no step that edge, tick=0. changed=1 only if the new B differs from the old B. terminal=0.
- Outputs: gray_count = B ^ (B>>1) and bin_count = B, both registered from the next-state value so they update on the same edge as B.
- Every step, including wrap, changes exactly one gray_count bit. Saturate holds change none.
- Arithmetic is modulo 2^bits. No internal width wider than bits except P.

## Timing
- Reset (async assert, released synchronously by the caller): gray_count=0, bin_count=0, tick=0, changed=0, terminal=0, P=0.
- Reset asserted mid-prescale discards the partial prescale. After release, the first step needs a full div enabled cycles.
- Latency: a step qualifying at edge k shows the new count and the tick/changed/terminal pulses during cycle k..k+1. All outputs are registered, with zero combinational paths from inputs to outputs.
- Strobes are exactly one cycle wide. With div=1 and enable held high, tick stays high continuously.
- up toggling between steps has no effect until the next step edge.
- load and step coinciding: load wins and the prescaler phase restarts.
- Step rate: one step per div enabled cycles. Gaps in enable stretch the period without losing phase.

## Test plan
- bits=4, div=1, wrap, enable=1, up=1 from reset, 17 cycles -> gray_count follows 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. terminal pulses once, on the 8→0 edge. tick high every cycle.
- bits=4, div=3, enable toggled 1,1,0,1 repeating -> one step per 3 enabled cycles. P holds across enable=0. tick is never high on consecutive cycles.
- bits=4, saturate=1, up=0 from reset, 3 steps -> count stays 0, terminal pulses 3 times, changed never asserts.
- bits=4, load_value=4'b1100 (bin 8), then up=0 with one step -> bin_count 8 then 7, gray_count 4'b1100 then 4'b0100. A load coinciding with a pending tick suppresses tick.
- div=5: assert async reset on the 3rd enabled cycle, mid-clock -> all outputs 0 immediately, without waiting for a clock edge. After release, the first tick comes exactly 5 enabled cycles later.
- bits=8, div=1, random up/enable/load for 10k cycles -> scoreboard matches B. Each non-load change of gray_count has Hamming distance 1. bin_count == gray2bin(gray_count) always.

Source files
------------

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: prescaled up/down Gray counter with load and wrap/saturate limits
// Ports: clk (rising edge), reset (async, active-high), enable (prescaler advance),
// up (1 = increment, 0 = decrement), load/load_value (Gray-coded synchronous load),
// gray_count/bin_count (registered views of the same count), tick/changed/terminal
// (one-cycle strobes for step taken, value changed, step attempted at a limit).
module gray_updown_counter #(
  parameter int unsigned bits = 8,
  parameter int unsigned div = 1,
  parameter bit saturate = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            load,
  input  logic [bits-1:0] load_value,
  output logic [bits-1:0] gray_count,
  output logic [bits-1:0] bin_count,
  output logic            tick,
  output logic            changed,
  output logic            terminal
);
  localparam int unsigned pw = div > 1 ? $clog2(div) : 1;
  localparam logic [pw-1:0] p_last = pw'(div - 1);
  function automatic logic [bits-1:0] gray2bin(input logic [bits-1:0] g);
    gray2bin = g;
    for (int i = int'(bits) - 2; i >= 0; i--) gray2bin[i] = gray2bin[i+1] ^ g[i];
  endfunction
  logic [pw-1:0] p, p_next;
  logic [bits-1:0] b_next, b_step;
  logic step, at_lim;
  always_comb begin
    step = enable && !load && p == p_last;
    at_lim = up ? &bin_count : ~|bin_count;
    b_step = (at_lim && saturate) ? bin_count : up ? bin_count + 1'b1 : bin_count - 1'b1;
    b_next = load ? gray2bin(load_value) : step ? b_step : bin_count;
    p_next = (load || step) ? '0 : enable ? p + 1'b1 : p;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p <= '0;
      bin_count <= '0;
      gray_count <= '0;
      tick <= 1'b0;
      changed <= 1'b0;
      terminal <= 1'b0;
    end else begin
      p <= p_next;
      bin_count <= b_next;
      gray_count <= b_next ^ (b_next >> 1);
      tick <= step;
      changed <= b_next != bin_count;
      terminal <= step && at_lim;
    end
endmodule
